coin_input_conditioner: RTL
===========================

COIN_INPUT_CONDITIONER -- requirements
Module: coin_input_conditioner

Interface
REQ-001 Parameter: DEBOUNCE, default 4, stable-sample count before a level change is accepted (legal range 2..255).
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 fifty_raw  input  1  asynchronous, bouncy 50-cent coin sensor, high while coin present.
REQ-005 dollar_raw  input  1  asynchronous, bouncy 1-dollar coin sensor, high while coin present.
REQ-006 cancel_raw  input  1  asynchronous, bouncy cancel button, high while pressed.
REQ-007 accept  input  1  downstream vending FSM is ready for coins (its insert-coin indication).
REQ-008 fifty  output  1  registered single-cycle 50-cent event to the vending FSM.
REQ-009 dollar  output  1  registered single-cycle 1-dollar event to the vending FSM.
REQ-010 cancel  output  1  registered single-cycle cancel event to the vending FSM.
REQ-011 coin_reject  output  1  registered single-cycle pulse commanding physical return of a refused coin.
REQ-012 pending  output  3  {cancel, dollar, fifty} queued-event flags, for status and debug.

Function
REQ-013 Each raw input SHALL pass through a two-flop synchronizer; only the second flop is used downstream.
REQ-014 Each channel SHALL keep a debounced level and a counter of width ceil(log2(DEBOUNCE)).
REQ-015 Counter SHALL clear on any edge where the synced value equals the debounced level.
REQ-016 Counter SHALL increment on each edge where they differ; at the edge where the count equals DEBOUNCE-1 and they still differ, the debounced level SHALL take the synced value and the counter SHALL clear.
REQ-017 A debounced 0->1 transition SHALL be one event; 1->0 transitions SHALL produce nothing.
REQ-018 The cancel event SHALL set pending[2] on the same edge as the debounced transition.
REQ-019 A coin event with accept=1 on that edge SHALL set its pending flag.
REQ-020 A coin event with accept=0 on that edge SHALL NOT set the flag and SHALL pulse coin_reject on the next cycle.
REQ-021 A coin event whose pending flag is already set SHALL be dropped with a coin_reject pulse; this takes priority over REQ-019.
REQ-022 At most one of fifty/dollar/cancel SHALL be high in any cycle.
REQ-023 Issue priority SHALL be cancel > dollar > fifty.
REQ-024 Coin flags SHALL be issued only on edges where accept=1; held coin flags SHALL wait indefinitely while accept=0.
REQ-025 cancel SHALL be issued regardless of accept.
REQ-026 The issuing edge SHALL clear the issued flag and raise the matching output for exactly one cycle.
REQ-027 If a new event for a channel and that channel's issue coincide, the flag SHALL end set (set wins).
REQ-028 Latency: with N the first edge sampling a raw input high, the input held stable, no contention and accept=1, the output pulse SHALL be high in the cycle after edge N+DEBOUNCE+2.
REQ-029 Raw pulses shorter than DEBOUNCE consecutive synced samples SHALL produce no event.
REQ-030 Simultaneous coin_reject causes in one cycle SHALL produce a single one-cycle pulse.

Reset
REQ-031 rst=1 at an edge SHALL clear synchronizers, debounced levels, counters, pending flags and all outputs to 0, overriding every other update.
REQ-032 A raw input held high across reset deassertion SHALL produce one event after normal debounce latency.
REQ-033 Reset asserted mid-debounce or with flags pending SHALL discard those events without output pulses.

Verification
REQ-034 DEBOUNCE=4, accept=1, fifty_raw high from edge 1 -> fifty high only in the cycle after edge 7, pending[0] high only in the cycle between edges 6 and 7.
REQ-035 fifty_raw toggling every 2 cycles for 20 cycles, then low -> no output pulses and no coin_reject.
REQ-036 fifty_raw, dollar_raw and cancel_raw rising on the same edge, accept=1 -> cancel, dollar and fifty pulses on three consecutive cycles, in that order.
REQ-037 accept=0 when a dollar debounces -> coin_reject pulse one cycle later, dollar never pulses, pending stays 0.
REQ-038 fifty pending with accept=0 for 10 cycles, then accept=1 -> fifty pulses in the cycle after the first edge with accept=1.
REQ-039 rst asserted for one edge while dollar is pending -> all outputs and pending read 0, and no dollar pulse follows.

Source files
------------

// File: rtl/coin_input_conditioner_if.sv
// Coin input conditioner bus.
// Carries the raw sensor/button levels and the downstream accept indication
// into the conditioner, and the conditioned event pulses, coin-return
// command and queued-event flags back out.
//   master : environment side, which drives the raw inputs and accept and reads the events
//   slave  : conditioner side, which reads the raw inputs and accept and drives the events
interface coin_input_conditioner_if;
  logic       fifty_raw;
  logic       dollar_raw;
  logic       cancel_raw;
  logic       accept;
  logic       fifty;
  logic       dollar;
  logic       cancel;
  logic       coin_reject;
  logic [2:0] pending;

  modport master (
    output fifty_raw, dollar_raw, cancel_raw, accept,
    input  fifty, dollar, cancel, coin_reject, pending
  );

  modport slave (
    input  fifty_raw, dollar_raw, cancel_raw, accept,
    output fifty, dollar, cancel, coin_reject, pending
  );
endinterface

// File: rtl/coin_input_conditioner.sv
// Coin input conditioner.
// This block synchronises and debounces the two coin sensors and the cancel
// button. It turns each debounced rising level into one event and queues the
// events as pending flags. It issues the events one at a time to the vending
// FSM, with cancel first, then dollar, then fifty. A coin that cannot be taken
// produces a coin-return pulse.
//   clk  : system clock, rising edge
//   rst  : synchronous, active-high reset
//   bus.fifty_raw / dollar_raw / cancel_raw : async bouncy inputs
//   bus.accept      : downstream ready for coins
//   bus.fifty / dollar / cancel : single-cycle registered events
//   bus.coin_reject : single-cycle coin-return command
//   bus.pending     : {cancel, dollar, fifty} queued-event flags
module coin_input_conditioner #(
  parameter int unsigned DEBOUNCE = 4
) (
  input logic                    clk,
  input logic                    rst,
  coin_input_conditioner_if.slave bus
);
  localparam int unsigned CW = $clog2(DEBOUNCE);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  // Channel index: 0 = fifty, 1 = dollar, 2 = cancel
  logic [2:0]    w_raw;
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_level;
  logic [CW-1:0] r_cnt [3];
  logic [2:0]    r_pending;
  logic          r_fifty;
  logic          r_dollar;
  logic          r_cancel;
  logic          r_coin_reject;

  logic [2:0]    w_rise;
  logic [2:0]    w_issue;
  logic [2:0]    w_set;
  logic          w_reject;
  logic [2:0]    w_pending_nxt;

  assign w_raw = {bus.cancel_raw, bus.dollar_raw, bus.fifty_raw};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_level <= '0;
      for (int unsigned i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int unsigned i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_level[i] <= r_sync2[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    w_rise  = '0;
    w_issue = '0;
    w_set   = '0;
    // The event is decoded from the pre-update state. The pending flag
    // therefore sets on the same edge that the debounced level rises.
    for (int unsigned i = 0; i < 3; i++)
      w_rise[i] = r_sync2[i] & ~r_level[i] & (r_cnt[i] == CNT_LAST);

    w_issue[2] = r_pending[2];
    w_issue[1] = ~r_pending[2] & bus.accept & r_pending[1];
    w_issue[0] = ~r_pending[2] & bus.accept & ~r_pending[1] & r_pending[0];

    // A coin whose flag is already set is refused even when accept is high.
    w_set[2]   = w_rise[2];
    w_set[1:0] = w_rise[1:0] & ~r_pending[1:0] & {2{bus.accept}};
    w_reject   = |(w_rise[1:0] & (r_pending[1:0] | {2{~bus.accept}}));

    w_pending_nxt = (r_pending & ~w_issue) | w_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending     <= '0;
      r_fifty       <= 1'b0;
      r_dollar      <= 1'b0;
      r_cancel      <= 1'b0;
      r_coin_reject <= 1'b0;
    end else begin
      r_pending     <= w_pending_nxt;
      r_fifty       <= w_issue[0];
      r_dollar      <= w_issue[1];
      r_cancel      <= w_issue[2];
      r_coin_reject <= w_reject;
    end
  end

  assign bus.fifty       = r_fifty;
  assign bus.dollar      = r_dollar;
  assign bus.cancel      = r_cancel;
  assign bus.coin_reject = r_coin_reject;
  assign bus.pending     = r_pending;
endmodule
